// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared types and constants for the USB full-speed transmit arbiter
package usb_pkg;

  localparam int USB_IPG_FS_CYCLES = 8;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    WAIT_EOP,
    GAP
  } usb_tx_arb_state_t;

endpackage

// File: rtl/usb_arb_pick.sv
// rtl/usb_arb_pick.sv - one-hot winner select; requester 0 always wins, endpoints
// use round-robin from ptr+1 when USB_TX_ARB_RR_EN is defined, else lowest index.
module usb_arb_pick #(
  parameter int REQ_N = 4,
  parameter int PW    = 2
) (
  input  logic [REQ_N-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [REQ_N-1:0] win
);

`ifdef USB_TX_ARB_RR_EN
  always_comb begin
    int   idx;
    logic found;
    win   = '0;
    idx   = 0;
    found = 1'b0;
    if (req[0]) begin
      win[0] = 1'b1;
    end else begin
      // Endpoint indices live in 1..REQ_N-1, so the wrap skips requester 0.
      for (int k = 1; k < REQ_N; k++) begin
        idx = int'(ptr) + k;
        if (idx > REQ_N - 1) idx = idx - (REQ_N - 1);
        if (!found && req[idx]) begin
          win[idx] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    logic found;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < REQ_N; i++) begin
      if (!found && req[i]) begin
        win[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/usb_tx_arb.sv
// rtl/usb_tx_arb.sv - per-packet arbiter muxing requester byte streams onto the SIE
// transmitter with inter-packet gap; USB_TX_ARB_RR_EN selects round-robin endpoints.
module usb_tx_arb
  import usb_pkg::*;
#(
  parameter int REQ_N      = 4,
  parameter int IPG_CYCLES = USB_IPG_FS_CYCLES
) (
  input  logic               clk_48m,
  input  logic               rst_n,
  input  logic               bus_reset,
  input  logic [REQ_N-1:0]   req_valid,
  input  logic [REQ_N*8-1:0] req_data,
  input  logic [REQ_N-1:0]   req_last,
  output logic [REQ_N-1:0]   req_ready,
  output logic               tx_valid,
  output logic [7:0]         tx_data,
  output logic               tx_last,
  input  logic               tx_ready,
  input  logic               tx_done,
  output logic [REQ_N-1:0]   grant,
  output logic               busy
);

  localparam int PW = $clog2(REQ_N);
  localparam int CW = (IPG_CYCLES > 0) ? $clog2(IPG_CYCLES + 1) : 1;
  localparam logic [CW-1:0] GAP_LOAD = (IPG_CYCLES > 0) ? CW'(IPG_CYCLES - 1) : '0;

  usb_tx_arb_state_t state, state_nxt;
  logic [REQ_N-1:0]  grant_q;
  logic [REQ_N-1:0]  pick_win;
  logic [PW-1:0]     rr_ptr;
  logic [CW-1:0]     gap_cnt;
  logic              any_req;

  assign any_req = |req_valid;

  usb_arb_pick #(
    .REQ_N (REQ_N),
    .PW    (PW)
  ) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .win (pick_win)
  );

`ifdef USB_TX_ARB_RR_EN
  logic [PW-1:0] win_idx;

  always_comb begin
    win_idx = '0;
    for (int i = 1; i < REQ_N; i++) begin
      if (pick_win[i]) win_idx = PW'(i);
    end
  end

  // Handshake grants leave the pointer alone so endpoints keep their rotation.
  always_ff @(posedge clk_48m or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= PW'(REQ_N - 1);
    end else if (bus_reset) begin
      rr_ptr <= PW'(REQ_N - 1);
    end else if (state == IDLE && any_req && !req_valid[0]) begin
      rr_ptr <= win_idx;
    end
  end
`else
  assign rr_ptr = PW'(REQ_N - 1);
`endif

  always_ff @(posedge clk_48m or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus_reset) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:     if (any_req) state_nxt = XFER;
        XFER:     if (tx_valid && tx_ready && tx_last) state_nxt = WAIT_EOP;
        WAIT_EOP: if (tx_done) state_nxt = (IPG_CYCLES == 0) ? IDLE : GAP;
        GAP:      if (gap_cnt == '0) state_nxt = IDLE;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_48m or negedge rst_n) begin
    if (!rst_n) begin
      grant_q <= '0;
      gap_cnt <= '0;
    end else if (bus_reset) begin
      grant_q <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (any_req) grant_q <= pick_win;
        WAIT_EOP: begin
          if (tx_done) begin
            grant_q <= '0;
            gap_cnt <= GAP_LOAD;
          end
        end
        GAP: if (gap_cnt != '0) gap_cnt <= gap_cnt - CW'(1);
        default: ;
      endcase
    end
  end

  // Straight combinational path from the owner to the transmitter, no buffering.
  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    tx_last   = 1'b0;
    req_ready = '0;
    if (state == XFER && !bus_reset) begin
      for (int i = 0; i < REQ_N; i++) begin
        if (grant_q[i]) begin
          tx_valid     = req_valid[i];
          tx_data      = req_data[i*8 +: 8];
          tx_last      = req_last[i];
          req_ready[i] = tx_ready;
        end
      end
    end
  end

  assign grant = grant_q;
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_usb_tx_arb.sv
// tb/tb_usb_tx_arb.sv - scoreboard bench for usb_tx_arb (default and IPG_CYCLES=0 builds)
module tb_usb_tx_arb;

  localparam int REQ_N = 4;
  localparam int IPG   = 8;

  logic               clk_48m = 1'b0;
  logic               rst_n;
  logic               bus_reset;
  logic [REQ_N-1:0]   req_valid, req_last, req_ready, grant;
  logic [REQ_N*8-1:0] req_data;
  logic               tx_valid, tx_last, tx_ready, tx_done, busy;
  logic [7:0]         tx_data;

  logic               z_bus_reset, z_tx_ready, z_tx_done;
  logic [REQ_N-1:0]   z_req_valid, z_req_last, z_req_ready, z_grant;
  logic [REQ_N*8-1:0] z_req_data;
  logic               z_tx_valid, z_tx_last, z_busy;
  logic [7:0]         z_tx_data;

  always #10 clk_48m = ~clk_48m;

  usb_tx_arb #(.REQ_N(REQ_N), .IPG_CYCLES(IPG)) dut (
    .clk_48m(clk_48m), .rst_n(rst_n), .bus_reset(bus_reset),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last), .tx_ready(tx_ready),
    .tx_done(tx_done), .grant(grant), .busy(busy)
  );

  usb_tx_arb #(.REQ_N(REQ_N), .IPG_CYCLES(0)) dut_z (
    .clk_48m(clk_48m), .rst_n(rst_n), .bus_reset(z_bus_reset),
    .req_valid(z_req_valid), .req_data(z_req_data), .req_last(z_req_last), .req_ready(z_req_ready),
    .tx_valid(z_tx_valid), .tx_data(z_tx_data), .tx_last(z_tx_last), .tx_ready(z_tx_ready),
    .tx_done(z_tx_done), .grant(z_grant), .busy(z_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [8:0]       src_q [REQ_N][$];
  logic [8:0]       exp_q [REQ_N][$];
  logic [REQ_N-1:0] exp_grant_q [$];
  logic [REQ_N-1:0] took = '0;
  logic [REQ_N-1:0] prev_grant = '0;
  int               beats = 0;
  int               mon_g;
  logic [8:0]       mon_e;

  task automatic update_reqs();
    for (int i = 0; i < REQ_N; i++) begin
      if (src_q[i].size() > 0) begin
        req_valid[i]      = 1'b1;
        req_data[i*8 +: 8] = src_q[i][0][7:0];
        req_last[i]       = src_q[i][0][8];
      end else begin
        req_valid[i]      = 1'b0;
        req_data[i*8 +: 8] = 8'h00;
        req_last[i]       = 1'b0;
      end
    end
  endtask

  task automatic push_byte(input int r, input logic [7:0] d, input logic l);
    src_q[r].push_back({l, d});
    exp_q[r].push_back({l, d});
  endtask

  // Requesters pop bytes accepted at the previous edge, then present the next one.
  always @(posedge clk_48m) begin
    #1;
    for (int i = 0; i < REQ_N; i++) begin
      if (took[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
    update_reqs();
  end

  always @(negedge clk_48m) begin
    took = req_valid & req_ready;
    if (rst_n) begin
      if (grant != prev_grant && grant != '0) begin
        if (exp_grant_q.size() == 0) check("grant_unexpected", grant, '0);
        else check("grant_order", grant, exp_grant_q.pop_front());
      end
      prev_grant = grant;
      if (tx_valid && tx_ready) begin
        beats++;
        check("req_ready_beat", req_ready, grant);
        mon_g = 0;
        for (int i = 0; i < REQ_N; i++) if (grant[i]) mon_g = i;
        if (exp_q[mon_g].size() == 0) begin
          check("beat_unexpected_qsize", exp_q[mon_g].size(), 1);
        end else begin
          mon_e = exp_q[mon_g].pop_front();
          check("tx_data", tx_data, mon_e[7:0]);
          check("tx_last", tx_last, mon_e[8]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_48m);
    #1;
  endtask

  task automatic wait_beats(input int target, input string tag);
    int n = 0;
    while (beats < target && n < 200) begin
      tick();
      n++;
    end
    check(tag, beats, target);
  endtask

  task automatic end_pkt(input string tag);
    int n = 0;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    check(tag, n, IPG);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst_n = 1'b0; bus_reset = 1'b0; tx_ready = 1'b1; tx_done = 1'b0;
    z_bus_reset = 1'b0; z_tx_ready = 1'b1; z_tx_done = 1'b0;
    z_req_valid = '0; z_req_last = '0; z_req_data = '0;
    req_valid = '0; req_last = '0; req_data = '0;
    repeat (3) tick();
    @(negedge clk_48m);
    check("rst_grant", grant, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_tx_last", tx_last, 1'b0);
    check("rst_req_ready", req_ready, '0);
    check("rst_z_busy", z_busy, 1'b0);
    rst_n = 1'b1;
    tick();

    // single packet from requester 2
    base = beats;
    push_byte(2, 8'hC3, 1'b0); push_byte(2, 8'h11, 1'b0); push_byte(2, 8'h22, 1'b1);
    exp_grant_q.push_back(4'b0100);
    update_reqs();
    tick();
    check("t1_grant", grant, 4'b0100);
    check("t1_tx_valid", tx_valid, 1'b1);
    check("t1_first_byte", tx_data, 8'hC3);
    wait_beats(base + 3, "t1_beats");
    check("t1_eop_tx_valid", tx_valid, 1'b0);
    check("t1_eop_busy", busy, 1'b1);
    end_pkt("t1_gap_len");
    check("t1_idle_grant", grant, '0);

    // handshake beats endpoint in the same IDLE cycle
    base = beats;
    push_byte(1, 8'h31, 1'b0); push_byte(1, 8'h32, 1'b1);
    push_byte(0, 8'hD2, 1'b1);
    exp_grant_q.push_back(4'b0001);
    exp_grant_q.push_back(4'b0010);
    update_reqs();
    tick();
    check("t2_grant_hs", grant, 4'b0001);
    wait_beats(base + 1, "t2_hs_beats");
    end_pkt("t2_gap_len");
    check("t2_gap_end_grant", grant, '0);
    tick();
    check("t2_grant_after_gap", grant, 4'b0010);
    wait_beats(base + 3, "t2_ep_beats");
    end_pkt("t2_gap_len2");

    // backpressure: tx_ready alternates during a 5-byte packet
    base = beats;
    for (int i = 0; i < 5; i++) push_byte(3, 8'h50 + 8'(i), (i == 4));
    exp_grant_q.push_back(4'b1000);
    update_reqs();
    tick();
    for (int n = 0; n < 40 && beats < base + 5; n++) begin
      tx_ready = (n % 2 == 0);
      @(negedge clk_48m);
      check("t3_req_ready", req_ready, tx_ready ? 4'b1000 : 4'b0000);
      tick();
    end
    tx_ready = 1'b1;
    check("t3_eop_tx_valid", tx_valid, 1'b0);
    end_pkt("t3_gap_len");
    check("t3_beat_count", beats, base + 5);

    // bus_reset after byte 2 of 4
    base = beats;
    for (int i = 0; i < 4; i++) push_byte(2, 8'h61 + 8'(i), (i == 3));
    exp_grant_q.push_back(4'b0100);
    update_reqs();
    tick();
    wait_beats(base + 2, "t4_beats_before");
    bus_reset = 1'b1;
    @(negedge clk_48m);
    check("t4_rst_tx_valid", tx_valid, 1'b0);
    check("t4_rst_req_ready", req_ready, '0);
    tick();
    bus_reset = 1'b0;
    check("t4_grant_cleared", grant, '0);
    check("t4_busy", busy, 1'b0);
    src_q[2].delete();
    exp_q[2].delete();
    update_reqs();
    repeat (3) tick();
    check("t4_no_more_beats", beats, base + 2);

    // endpoints 1..3 continuously requesting
    base = beats;
    push_byte(1, 8'h41, 1'b1); push_byte(1, 8'h42, 1'b1); push_byte(1, 8'h43, 1'b1);
    push_byte(2, 8'h51, 1'b1);
    push_byte(3, 8'h61, 1'b1);
`ifdef USB_TX_ARB_RR_EN
    exp_grant_q.push_back(4'b0010); exp_grant_q.push_back(4'b0100);
    exp_grant_q.push_back(4'b1000); exp_grant_q.push_back(4'b0010);
    exp_grant_q.push_back(4'b0010);
`else
    exp_grant_q.push_back(4'b0010); exp_grant_q.push_back(4'b0010);
    exp_grant_q.push_back(4'b0010); exp_grant_q.push_back(4'b0100);
    exp_grant_q.push_back(4'b1000);
`endif
    update_reqs();
    for (int p = 0; p < 5; p++) begin
      wait_beats(base + p + 1, "t5_beats");
      end_pkt("t5_gap_len");
    end

    // zero-gap build: pending request granted right after IDLE
    z_req_valid = 4'b0010; z_req_last = 4'b0010; z_req_data[15:8] = 8'h77;
    tick();
    check("t6_grant", z_grant, 4'b0010);
    check("t6_tx_data", z_tx_data, 8'h77);
    tick();
    z_req_data[15:8] = 8'h78;
    check("t6_eop_tx_valid", z_tx_valid, 1'b0);
    check("t6_eop_busy", z_busy, 1'b1);
    z_tx_done = 1'b1;
    tick();
    z_tx_done = 1'b0;
    check("t6_idle_busy", z_busy, 1'b0);
    check("t6_idle_grant", z_grant, '0);
    tick();
    check("t6_regrant", z_grant, 4'b0010);
    check("t6_regrant_data", z_tx_data, 8'h78);
    z_req_valid = '0;

    check("grants_left", exp_grant_q.size(), 0);
    for (int i = 0; i < REQ_N; i++) check("bytes_left", exp_q[i].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
